hazard_unit: RTL
================

HAZARD_UNIT -- requirements
Module: hazard_unit

Interface
REQ-001 SHALL: clock  in  1  single rising-edge clock.
REQ-002 SHALL: reset_n  in  1  asynchronous, active-low reset.
REQ-003 SHALL: rs_f2, rt_f2  in  5 each  source registers of the instruction in ID (stage 2).
REQ-004 SHALL: usa_rt_f2  in  1  ID instruction reads rt.
REQ-005 SHALL: hilo_rd_f2  in  1  ID instruction reads HI/LO (mfhi/mflo).
REQ-006 SHALL: memread_f3  in  1  EX (stage 3) instruction is a load.
REQ-007 SHALL: escrita_f3  in  5  EX destination register.
REQ-008 SHALL: mdu_op_f3  in  2  EX multiply/divide op: 00 none, 01 mult, 10 div, 11 treated as none.
REQ-009 SHALL: branch_f3  in  1  taken branch/jump resolved in EX.
REQ-010 SHALL: pc_write, ifid_write, idex_write  out  1 each  register write enables, 1 = advance.
REQ-011 SHALL: idex_bubble  out  1  load NOP into ID/EX instead of the ID instruction.
REQ-012 SHALL: flush_f2  out  1  squash IF/ID contents.
REQ-013 SHALL: mdu_busy  out  1  multi-cycle unit occupied.
REQ-014 SHALL: stall_cnt  out  16  count of cycles with pc_write = 0.

Function
REQ-015 SHALL: hold state RUN or MDU plus a 5-bit down-counter cnt; all outputs except stall_cnt are combinational from state, cnt and current inputs.
REQ-016 SHALL: define load-use hazard LU = memread_f3 & escrita_f3 != 0 & (escrita_f3 == rs_f2 | (usa_rt_f2 & escrita_f3 == rt_f2)).
REQ-017 SHALL: define HILO hazard HL = hilo_rd_f2 & state == MDU.
REQ-018 SHALL: define structural hold SH = state == MDU & cnt != 0 & mdu_op_f3 in {01,10}.
REQ-019 SHALL: apply priority, highest first: SH -> pc_write = ifid_write = idex_write = 0, idex_bubble = 0, flush_f2 = 0.
REQ-020 SHALL: next, branch_f3 -> flush_f2 = 1, idex_bubble = 1, pc_write = ifid_write = idex_write = 1; LU/HL ignored.
REQ-021 SHALL: next, LU or HL -> pc_write = ifid_write = 0, idex_write = 1, idex_bubble = 1, flush_f2 = 0.
REQ-022 SHALL: otherwise pc_write = ifid_write = idex_write = 1, idex_bubble = flush_f2 = 0.
REQ-023 SHALL: in RUN with mdu_op_f3 = 01, load cnt = 3 and enter MDU (4 busy cycles); with 10, load cnt = 31 (32 busy cycles).
REQ-024 SHALL: in MDU with cnt != 0, decrement cnt each cycle.
REQ-025 SHALL: in MDU with cnt == 0, go to RUN, unless mdu_op_f3 in {01,10}: then reload per REQ-023 and remain in MDU (back-to-back, no gap cycle).
REQ-026 SHALL: mdu_busy = 1 exactly while state == MDU, including the cnt == 0 cycle; HI/LO read proceeds the cycle after return to RUN.
REQ-027 SHALL: increment stall_cnt on each rising edge where pc_write = 0; saturate at 16'hFFFF.
REQ-028 SHALL: treat escrita_f3 == 0 as never hazardous (write to $zero).

Reset
REQ-029 SHALL: on reset_n = 0, immediately and asynchronously set state = RUN, cnt = 0, stall_cnt = 0.
REQ-030 SHALL: while reset_n = 0, force pc_write = ifid_write = idex_write = 1, idex_bubble = flush_f2 = mdu_busy = 0, regardless of inputs.
REQ-031 SHALL: reset asserted during MDU abort the operation; first cycle after release is RUN with mdu_busy = 0.

Verification
REQ-032 SHALL: lw $5 in EX (memread_f3 = 1, escrita_f3 = 5), ID rs_f2 = 5 -> one cycle pc_write = 0, ifid_write = 0, idex_bubble = 1; stall_cnt 0 -> 1.
REQ-033 SHALL: escrita_f3 = 0, rs_f2 = 0, memread_f3 = 1 -> no stall; rt_f2 = 5 with usa_rt_f2 = 0 -> no stall.
REQ-034 SHALL: mdu_op_f3 = 10 in RUN then mfhi held in ID -> mdu_busy high 32 cycles, ID stalled 32 cycles, mfhi advances cycle 33, stall_cnt = 32.
REQ-035 SHALL: mult then second mult in EX during busy -> SH freezes all three enables until cnt == 0 cycle, reload cnt = 3, mdu_busy stays 1 continuously for 8 cycles.
REQ-036 SHALL: branch_f3 = 1 coincident with LU -> flush_f2 = 1, idex_bubble = 1, pc_write = 1, stall_cnt unchanged.
REQ-037 SHALL: reset_n pulsed low at cnt = 17 of a div -> mdu_busy = 0 asynchronously, stall_cnt = 0, state RUN after release.

Source files
------------

// File: rtl/hazard_unit.sv
// Pipeline hazard unit: load-use / HI-LO interlocks, branch flush and a
// multi-cycle multiply/divide occupancy tracker with a stall-cycle counter.
//
// state | meaning
// RUN   | no multiply/divide in flight
// MDU   | multiply/divide unit busy, cnt counts remaining busy cycles down to 0
module hazard_unit (
  input  logic        clock,
  input  logic        reset_n,
  input  logic [4:0]  rs_f2,
  input  logic [4:0]  rt_f2,
  input  logic        usa_rt_f2,
  input  logic        hilo_rd_f2,
  input  logic        memread_f3,
  input  logic [4:0]  escrita_f3,
  input  logic [1:0]  mdu_op_f3,
  input  logic        branch_f3,
  output logic        pc_write,
  output logic        ifid_write,
  output logic        idex_write,
  output logic        idex_bubble,
  output logic        flush_f2,
  output logic        mdu_busy,
  output logic [15:0] stall_cnt
);

  typedef enum logic {RUN = 1'b0, MDU = 1'b1} state_t;

  state_t     state, state_nxt;
  logic [4:0] cnt, cnt_nxt;
  logic       mdu_start;
  logic [4:0] mdu_reload;
  logic       lu, hl, sh;

  // Only 01 (mult) and 10 (div) occupy the unit; 11 is treated as no-op.
  assign mdu_start  = (mdu_op_f3 == 2'b01) || (mdu_op_f3 == 2'b10);
  assign mdu_reload = (mdu_op_f3 == 2'b10) ? 5'd31 : 5'd3;

  assign lu = memread_f3 && (escrita_f3 != 5'd0) &&
              ((escrita_f3 == rs_f2) || (usa_rt_f2 && (escrita_f3 == rt_f2)));
  assign hl = hilo_rd_f2 && (state == MDU);
  assign sh = (state == MDU) && (cnt != 5'd0) && mdu_start;

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state     <= RUN;
      cnt       <= 5'd0;
      stall_cnt <= 16'd0;
    end else begin
      state <= state_nxt;
      cnt   <= cnt_nxt;
      if (!pc_write && (stall_cnt != 16'hFFFF))
        stall_cnt <= stall_cnt + 16'd1;
    end
  end

  always_comb begin
    state_nxt   = state;
    cnt_nxt     = cnt;
    pc_write    = 1'b1;
    ifid_write  = 1'b1;
    idex_write  = 1'b1;
    idex_bubble = 1'b0;
    flush_f2    = 1'b0;
    mdu_busy    = 1'b0;

    case (state)
      RUN: begin
        if (mdu_start) begin
          state_nxt = MDU;
          cnt_nxt   = mdu_reload;
        end
      end
      MDU: begin
        // A new op reaching EX on the final busy cycle chains with no gap.
        if (cnt != 5'd0)
          cnt_nxt = cnt - 5'd1;
        else if (mdu_start)
          cnt_nxt = mdu_reload;
        else
          state_nxt = RUN;
      end
      default: begin
        state_nxt = RUN;
        cnt_nxt   = 5'd0;
      end
    endcase

    if (reset_n) begin
      mdu_busy = (state == MDU);
      if (sh) begin
        pc_write   = 1'b0;
        ifid_write = 1'b0;
        idex_write = 1'b0;
      end else if (branch_f3) begin
        flush_f2    = 1'b1;
        idex_bubble = 1'b1;
      end else if (lu || hl) begin
        pc_write    = 1'b0;
        ifid_write  = 1'b0;
        idex_bubble = 1'b1;
      end
    end
  end

endmodule
